gate_bist: RTL

Sequential built-in self-test engine for the 2-input bitwise gates of the nand2cpu library. It drives every combination of the gate-under-test operands `a`/`b`, waits a settle interval, samples the gate output `y`, and compares it with the expected function. It reports pass/fail, a saturating error count and the first failing vector. It sits beside a gate instance (or_gate, and_gate, …) and is the automated response-checking end of the stimulus path that the gate benches drive by hand.

---
 rtl/gate_bist.sv | 115 +++++++++++
 1 files changed

// File: rtl/gate_bist.sv
// Exhaustive BIST for 2-input bitwise gates.
// Sweeps a/b, settles, samples y, and tallies mismatches.
module gate_bist #(
  parameter int WIDTH  = 1,
  parameter int OP     = 1,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  localparam int VW = 2 * WIDTH;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CLAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state;
  logic [VW-1:0]    vec;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] exp_y;
  logic             miss;
  logic [7:0]       err_nx;

  assign a = vec[WIDTH-1:0];
  assign b = vec[VW-1:WIDTH];

  always_comb begin
    exp_y = '0;
    unique case (1'b1)
      (OP == 0): exp_y = a & b;
      (OP == 1): exp_y = a | b;
      (OP == 2): exp_y = a ^ b;
      default:   exp_y = ~(a & b);
    endcase
  end

  assign miss   = (y != exp_y);
  assign err_nx = (miss && err_count != 8'hFF)
                ? err_count + 8'd1 : err_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      vec       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 8'd0;
      fail_a    <= '0;
      fail_b    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            vec       <= '0;
            cnt       <= '0;
            err_count <= 8'd0;
            fail_a    <= '0;
            fail_b    <= '0;
            busy      <= 1'b1;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == CLAST) begin
            state <= S_CHECK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_CHECK: begin
          err_count <= err_nx;
          // only the first failing vector is kept
          if (miss && err_count == 8'd0) begin
            fail_a <= a;
            fail_b <= b;
          end
          if (&vec) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nx == 8'd0);
            state <= S_DONE;
          end else begin
            vec   <= vec + VW'(1);
            cnt   <= '0;
            state <= S_WAIT;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
